cache_lru_gen: RTL

Parametrised true-LRU replacement tracker for the set-associative caches, generalising the fixed 4-way / 2048-set tracker. Each set stores its full recency order. Per lookup, the block returns the least-recently-used way one cycle after the address, and commits the requested recency update one cycle later. A read-through bypass keeps back-to-back accesses to the same set coherent. A built-in initialisation sequencer sweeps every set to a known order after reset, and an optional demote operation marks a way as next victim, for invalidation.

---
 rtl/cache_lru_gen.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cache_lru_gen.sv
// rtl/cache_lru_gen.sv - true-LRU recency tracker with init sweep and same-set read bypass
// Defining CACHE_LRU_DEMOTE_EN enables the demote (make-LRU) update type.
module cache_lru_gen #(
  parameter int WAYS     = 4,
  parameter int SET_BITS = 11,
  parameter int IDX_W    = $clog2(WAYS)
) (
  input  logic                main_clk,
  input  logic                main_reset,
  input  logic [SET_BITS-1:0] addr,
  input  logic [IDX_W-1:0]    used_index,
  input  logic                enable_write,
  input  logic                demote,
  output logic [IDX_W-1:0]    least_used_index,
  output logic                ready
);
  localparam int LIST_W = WAYS * IDX_W;
  localparam int SETS   = 1 << SET_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t state, state_next;

  logic [SET_BITS-1:0] init_cnt;
  logic [LIST_W-1:0]   mem [SETS];
  logic [LIST_W-1:0]   rd_list, byp_list, cur_list, init_list, touch_list, upd_list;
  logic                byp_hit;
  logic                s1_en;
  logic [SET_BITS-1:0] s1_addr;
  logic [IDX_W-1:0]    s1_used;
  logic [IDX_W-1:0]    pos;
  logic                wr_en;
  logic [SET_BITS-1:0] wr_addr;
  logic [LIST_W-1:0]   wr_data;

  always_ff @(posedge main_clk) begin
    if (main_reset) state <= ST_INIT;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ST_INIT && (&init_cnt)) state_next = ST_RUN;
  end

  always_comb begin
    ready            = (state == ST_RUN) && !main_reset;
    least_used_index = ready ? cur_list[LIST_W-1 -: IDX_W] : '0;
  end

  always_ff @(posedge main_clk) begin
    if (main_reset || state != ST_INIT) init_cnt <= '0;
    else                                init_cnt <= init_cnt + 1'b1;
  end

  // Stage-1 request registers; the bypass flag marks a read that raced its own set's write.
  always_ff @(posedge main_clk) begin
    if (main_reset) begin
      s1_en   <= 1'b0;
      s1_addr <= '0;
      s1_used <= '0;
      byp_hit <= 1'b0;
    end else begin
      s1_en   <= enable_write && (state == ST_RUN);
      s1_addr <= addr;
      s1_used <= used_index;
      byp_hit <= s1_en && (s1_addr == addr);
    end
  end

  always_ff @(posedge main_clk) begin
    byp_list <= upd_list;
    rd_list  <= mem[addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign cur_list = byp_hit ? byp_list : rd_list;

  always_comb begin
    init_list = '0;
    for (int k = 0; k < WAYS; k++) init_list[k*IDX_W +: IDX_W] = IDX_W'(k);
  end

  always_comb begin
    pos = '0;
    for (int k = 0; k < WAYS; k++)
      if (cur_list[k*IDX_W +: IDX_W] == s1_used) pos = IDX_W'(k);
  end

  always_comb begin
    touch_list = cur_list;
    for (int k = 1; k < WAYS; k++)
      if (IDX_W'(k) <= pos) touch_list[k*IDX_W +: IDX_W] = cur_list[(k-1)*IDX_W +: IDX_W];
    touch_list[IDX_W-1:0] = s1_used;
  end

`ifdef CACHE_LRU_DEMOTE_EN
  logic              s1_demote;
  logic [LIST_W-1:0] demote_list;

  always_ff @(posedge main_clk) begin
    if (main_reset) s1_demote <= 1'b0;
    else            s1_demote <= demote;
  end

  always_comb begin
    demote_list = cur_list;
    for (int k = 0; k < WAYS-1; k++)
      if (IDX_W'(k) >= pos) demote_list[k*IDX_W +: IDX_W] = cur_list[(k+1)*IDX_W +: IDX_W];
    demote_list[LIST_W-1 -: IDX_W] = s1_used;
  end

  assign upd_list = s1_demote ? demote_list : touch_list;
`else
  logic unused_demote;
  assign unused_demote = demote;
  assign upd_list      = touch_list;
`endif

  // The init sweep owns the write port until RUN; nothing is written while reset is held.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = s1_addr;
    wr_data = upd_list;
    if (!main_reset) begin
      if (state == ST_INIT) begin
        wr_en   = 1'b1;
        wr_addr = init_cnt;
        wr_data = init_list;
      end else begin
        wr_en = s1_en;
      end
    end
  end
endmodule
